instr_encoder_loader: RTL and testbench
=======================================

# instr_encoder_loader

Builds programs for the single-cycle MIPS datapath, acting as the write side for the control unit's instruction decode. It accepts symbolic operation requests over a valid/ready handshake, encodes each into a 32-bit MIPS instruction word, and buffers the words in a small FIFO. It then streams them into instruction memory at sequential word addresses, with end-of-program draining and address reload.

## Interface
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- ADDR_W, 8, instruction-memory word-address width
- BASE_ADDR, 0, first word address of each program
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- in_op  in  4  op kind (package constants)
- in_rs / in_rt / in_rd  in  5 each  register fields
- in_imm  in  16  immediate (I-type only)
- in_last  in  1  final instruction of program
- imem_we  out  1  write valid (FIFO non-empty)
- imem_ready  in  1  memory accepts write when imem_we && imem_ready
- imem_addr  out  ADDR_W  word address
- imem_wdata  out  32  encoded instruction
- done  out  1  one-cycle pulse after last word written
- err  out  1  sticky illegal-op flag (ENC_ILLEGAL_CHECK_EN only; else tied 0)

## Operation
- Op kinds: ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, ADDI=8, LW=9, SW=10; all other values illegal.
- R-type: {6'b000000, rs, rt, rd, 5'b0, funct}; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, XOR 0x26, NOR 0x27.
- I-type: {opcode, rs, rt, imm}; ADDI 0x08, LW 0x23, SW 0x2B. For LW/SW, rt is the data register and rs the base.
- Encoding is combinational into the FIFO write. The FIFO stores {last, word}.
- FSM RUN/DRAIN:
  - RUN: in_ready = !full. Accepting with in_last=1 moves to DRAIN.
  - DRAIN: in_ready = 0. Popping the last-marked entry pulses done next cycle, reloads imem_addr to BASE_ADDR, and returns to RUN.
- Pop on imem_we && imem_ready; imem_addr increments by 1 per pop, wrapping 2^ADDR_W−1 → 0 silently.
- Push and pop in the same cycle leave the level unchanged. When full, in_ready is 0 even if a pop occurs that cycle, so no combinational ready path exists.
- Reset: FIFO empty, state RUN, imem_addr = BASE_ADDR. in_ready=1, imem_we=0, done=0, err=0. Reset mid-program discards all buffered words; no partial-program completion occurs.

## Timing
- Word accepted at edge N appears on imem_wdata/imem_we from cycle N+1 at the earliest.
- imem_wdata/imem_addr are held stable while imem_we && !imem_ready.
- Full throughput is one word per cycle when imem_ready stays high.
- done is asserted exactly one cycle, in the cycle after the last-marked pop. imem_addr already shows BASE_ADDR in that cycle.

## Configuration
- ENC_ILLEGAL_CHECK_EN defined:
  - An illegal in_op is still handshaken but not enqueued, and err sets and holds until rst.
  - If the illegal request carries in_last, a NOP (32'h00000000) with the last marker is enqueued instead, so program termination is preserved.
- Undefined: an illegal in_op is enqueued as NOP 32'h00000000 with its in_last flag, and err is constant 0.

## Structure
- Shared package enc_pkg: op-kind constants, opcode/funct localparams (matching the control unit's values), and the FSM state enum.
- One sub-module: sync_fifo (DEPTH, WIDTH=33), with push/pop/full/empty. The top holds the encoder, FSM, and address counter.

## Test plan
- ADD rs=1 rt=2 rd=3, imem_ready=1 → one write, imem_addr=0x00, imem_wdata=0x00221820.
- LW rs=29 rt=8 imm=4, then SW with the same fields → writes 0x8FA80004 at 0x00 and 0xAFA80004 at 0x01; ADDI rs=0 rt=5 imm=0xFFFF → 0x2005FFFF at 0x02.
- imem_ready=0, push 5 requests → in_ready low after the 4th accepted. Raise imem_ready → 4 writes on consecutive cycles at consecutive addresses, then the 5th is accepted.
- 3-op program with in_last on the 3rd → in_ready=0 after it. done pulses one cycle after the 3rd write, and the next program starts at BASE_ADDR.
- rst asserted with 3 words buffered and imem_ready=0 → next cycle imem_we=0, imem_addr=BASE_ADDR, in_ready=1; no write of the stale words.
- in_op=7: with ENC_ILLEGAL_CHECK_EN → no write and err=1 until rst. Without it → 0x00000000 written.

Source files
------------

// File: rtl/enc_pkg.sv
// enc_pkg: op kinds, MIPS opcode/funct values, loader FSM states and the word encoder.
package enc_pkg;
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_ADDI = 4'd8;
  localparam logic [3:0] OP_LW   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  typedef enum logic {RUN, DRAIN} state_e;
  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_NOR || (op >= OP_ADDI && op <= OP_SW);
  endfunction
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rs, rt, rd,
                                         input logic [15:0] imm);
    logic [5:0] fn, opc;
    fn = op == OP_ADD ? FN_ADD : op == OP_SUB ? FN_SUB : op == OP_AND ? FN_AND :
         op == OP_OR ? FN_OR : op == OP_XOR ? FN_XOR : FN_NOR;
    opc = op == OP_ADDI ? OPC_ADDI : op == OP_LW ? OPC_LW : OPC_SW;
    return op < OP_ADDI ? {OPC_RTYPE, rs, rt, rd, 5'd0, fn} : {opc, rs, rt, imm};
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter; push when full / pop when empty are ignored.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic do_push, do_pop;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign rdata_o = mem_q[rp_q];
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= wdata_i;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wp_q <= wp_q + 1'b1;
      if (do_pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes op requests into MIPS words and streams them into imem.
// ENC_ILLEGAL_CHECK_EN drops illegal ops (NOP kept if it carries last) and raises sticky err.
module instr_encoder_loader
  import enc_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [15:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              done,
  output logic              err
);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic done_q;
  logic full, empty, push, pop, legal, accept, pop_last;
  logic [32:0] wr_data, rd_data;
  assign legal    = op_legal(in_op);
  assign in_ready = state_q == RUN && !full;
  assign accept   = in_valid && in_ready;
  assign pop      = !empty && imem_ready;
  assign pop_last = pop && rd_data[32];
  assign wr_data  = {in_last, legal ? encode(in_op, in_rs, in_rt, in_rd, in_imm) : 32'h0};
`ifdef ENC_ILLEGAL_CHECK_EN
  logic err_q;
  assign push = accept && (legal || in_last);
  assign err  = err_q;
  always_ff @(posedge clk) err_q <= rst ? 1'b0 : err_q | (accept && !legal);
`else
  assign push = accept;
  assign err  = 1'b0;
`endif
  sync_fifo #(.DEPTH(DEPTH), .WIDTH(33)) u_fifo (
    .clk(clk), .rst(rst), .push_i(push), .pop_i(pop), .wdata_i(wr_data),
    .rdata_o(rd_data), .full_o(full), .empty_o(empty)
  );
  assign imem_we    = !empty;
  assign imem_wdata = rd_data[31:0];
  assign imem_addr  = addr_q;
  assign done       = done_q;
  always_comb begin
    addr_d  = pop_last ? BASE : pop ? addr_q + 1'b1 : addr_q;
    state_d = state_q == RUN && accept && in_last ? DRAIN :
              state_q == DRAIN && pop_last ? RUN : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      addr_q  <= BASE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      done_q  <= pop_last;
    end
  end
endmodule

// File: tb/tb_instr_encoder_loader.sv
// tb_instr_encoder_loader: directed plus random stimulus against a queue-based reference model.
module tb_instr_encoder_loader;
  localparam int DEPTH = 4;
  localparam logic [7:0] BASE = 8'd0;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_last = 0, imem_we, imem_ready = 0, done, err;
  logic [3:0] in_op = 0;
  logic [4:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [15:0] in_imm = 0;
  logic [7:0] imem_addr;
  logic [31:0] imem_wdata;
  int n_chk = 0, n_pass = 0;
  logic [32:0] mq[$];
  logic [7:0] m_addr = BASE;
  logic m_drain = 0, m_done = 0, m_err = 0;
  int fn_tab[6] = '{'h20, 'h22, 'h24, 'h25, 'h26, 'h27};
  int opc_tab[3] = '{'h08, 'h23, 'h2B};
  int legal_ops[9] = '{0, 1, 2, 3, 4, 5, 8, 9, 10};

  instr_encoder_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm), .in_last(in_last),
    .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  function automatic int unsigned ref_word(input int op, input int rs, rt, rd, imm);
    if (op <= 5) return rs * 2**21 + rt * 2**16 + rd * 2**11 + fn_tab[op];
    if (op >= 8 && op <= 10) return opc_tab[op-8] * 2**26 + rs * 2**21 + rt * 2**16 + imm;
    return 0;
  endfunction

  task automatic cycle(input logic r, v, input logic [3:0] op, input logic [4:0] rs, rt, rd,
                       input logic [15:0] imm, input logic last, rdy, input logic [32:0] lit);
    logic er, acc, pop, legal;
    @(negedge clk);
    er = !m_drain && mq.size() < DEPTH;
    check("in_ready", 32'(in_ready), 32'(er));
    check("imem_we", 32'(imem_we), 32'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("wdata", imem_wdata, mq[0][31:0]);
      check("addr", 32'(imem_addr), 32'(m_addr));
    end
    if (lit[32]) check("lit_wdata", imem_wdata, lit[31:0]);
    check("done", 32'(done), 32'(m_done));
    check("err", 32'(err), 32'(m_err));
    rst = r; in_valid = v; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_last = last; imem_ready = rdy;
    if (r) begin
      mq.delete(); m_addr = BASE; m_drain = 0; m_done = 0; m_err = 0;
    end else begin
      pop = mq.size() != 0 && rdy;
      acc = v && er;
      legal = op <= 5 || (op >= 8 && op <= 10);
      m_done = pop && mq[0][32];
      if (pop) begin
        if (mq[0][32]) begin m_addr = BASE; m_drain = 0; end
        else m_addr = m_addr + 8'd1;
        void'(mq.pop_front());
      end
      if (acc) begin
`ifdef ENC_ILLEGAL_CHECK_EN
        if (!legal) m_err = 1;
        if (legal || last) mq.push_back({last, ref_word(op, rs, rt, rd, imm)});
`else
        mq.push_back({last, ref_word(op, rs, rt, rd, imm)});
`endif
        if (last) m_drain = 1;
      end
    end
  endtask

  task automatic idle(input logic rdy, input logic [32:0] lit);
    cycle(0, 0, 0, 0, 0, 0, 0, 0, rdy, lit);
  endtask

  task automatic do_reset();
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 0);
  endtask

  initial begin
    do_reset();
    cycle(0, 1, 4'd0, 5'd1, 5'd2, 5'd3, 16'd0, 0, 1, 0);
    idle(1, {1'b1, 32'h00221820});
    idle(1, 0);
    do_reset();
    cycle(0, 1, 4'd9, 5'd29, 5'd8, 5'd0, 16'd4, 0, 1, 0);
    cycle(0, 1, 4'd10, 5'd29, 5'd8, 5'd0, 16'd4, 0, 1, {1'b1, 32'h8FA80004});
    cycle(0, 1, 4'd8, 5'd0, 5'd5, 5'd0, 16'hFFFF, 0, 1, {1'b1, 32'hAFA80004});
    idle(1, {1'b1, 32'h2005FFFF});
    idle(1, 0);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(0, 1, 4'(i % 6), 5'(i), 5'(i + 1), 5'(i + 2), 16'd0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 4'd1, 5'd7, 5'd7, 5'd7, 16'd0, 0, 1, 0);
    idle(1, 0);
    idle(1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'd3, 5'(i), 5'd9, 5'd10, 16'd0, i == 2, 1, 0);
    cycle(0, 1, 4'd0, 5'd1, 5'd1, 5'd1, 16'd0, 0, 1, 0);
    for (int i = 0; i < 5; i++) idle(1, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 4'd2, 5'd3, 5'd4, 5'(i), 16'd0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(1, 0);
    idle(1, 0);
    cycle(0, 1, 4'd7, 5'd1, 5'd2, 5'd3, 16'd0, 0, 1, 0);
    idle(1, 0);
    idle(1, 0);
    cycle(0, 1, 4'd7, 5'd1, 5'd2, 5'd3, 16'd0, 1, 1, 0);
    for (int i = 0; i < 4; i++) idle(1, 0);
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = $urandom_range(0, 4) == 0 ? 4'($urandom_range(0, 15)) : 4'(legal_ops[$urandom_range(0, 8)]);
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 6, op, 5'($urandom), 5'($urandom),
            5'($urandom), 16'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 9) < 7, 0);
    end
    for (int i = 0; i < 10; i++) idle(1, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
